// File: rtl/mem_io_responder.sv
// mem_io_responder: memory-side responder for the byte-wide CPU bus.
// Serves RAM reads/writes with one-cycle registered read latency, decodes the
// I/O window at 0x30000 (RX input, TX FIFO, program stop, cycle counter).
// Optional feature macro: MEM_IO_CYCLE_COUNTER_EN enables the 32-bit cycle
// counter and its read snapshot at 0x30004-0x30007; without it those reads
// return 0x00.
module mem_io_responder #(
    parameter int ADDR_WIDTH    = 17,
    parameter int TX_DEPTH_LOG2 = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] in_cpu_addr,
    input  logic        in_cpu_wr,
    input  logic [7:0]  in_cpu_data,
    output logic [7:0]  out_cpu_data,
    output logic        out_io_buffer_full,
    output logic [7:0]  out_tx_data,
    output logic        out_tx_valid,
    input  logic        in_tx_ready,
    input  logic [7:0]  in_rx_data,
    input  logic        in_rx_valid,
    output logic        out_rx_pop,
    output logic        out_program_stop,
    output logic        out_tx_overflow
);

    localparam int RAM_BYTES = 1 << ADDR_WIDTH;
    localparam int TX_DEPTH  = 1 << TX_DEPTH_LOG2;
    localparam int PW        = TX_DEPTH_LOG2;
    localparam int CW        = TX_DEPTH_LOG2 + 1;
    // Near-full asserts with two or fewer free slots so the core, which
    // reacts one cycle late, can still land its in-flight byte.
    localparam logic [CW-1:0] NEAR_FULL_CNT = CW'(TX_DEPTH - 2);
    localparam logic [CW-1:0] FULL_CNT      = CW'(TX_DEPTH);

    // ------------------------------------------------------------------
    // Address decode
    // ------------------------------------------------------------------
    logic        is_io;
    logic [15:0] io_off;
    logic        is_io_data;     // 0x30000: RX read / TX write
    logic        is_io_ctl;      // 0x30004: stop write / snapshot-load read
    logic        is_io_ctr;      // 0x30004-0x30007: counter bytes
    logic        rd_en;
    logic        wr_en;
    logic [ADDR_WIDTH-1:0] ram_addr;
    logic        unused_addr_bits;

    assign is_io      = (in_cpu_addr[17:16] == 2'b11);
    assign io_off     = in_cpu_addr[15:0];
    assign is_io_data = is_io && (io_off == 16'h0000);
    assign is_io_ctl  = is_io && (io_off == 16'h0004);
    assign is_io_ctr  = is_io && (io_off[15:2] == 14'h0001);
    assign rd_en      = !in_cpu_wr;
    assign wr_en      = in_cpu_wr;
    assign ram_addr   = in_cpu_addr[ADDR_WIDTH-1:0];
    assign unused_addr_bits = ^in_cpu_addr[31:18];

    // ------------------------------------------------------------------
    // RAM: contents survive reset; writes are blocked while reset is high
    // ------------------------------------------------------------------
    logic [7:0] ram [0:RAM_BYTES-1];
    logic [7:0] ram_rd_q;

    // RAM write port
    always_ff @(posedge clk) begin
        if (!rst && wr_en && !is_io) begin
            ram[ram_addr] <= in_cpu_data;
        end
    end

    // RAM registered read port, only refreshed by RAM reads
    always_ff @(posedge clk) begin
        if (rd_en && !is_io) begin
            ram_rd_q <= ram[ram_addr];
        end
    end

    // ------------------------------------------------------------------
    // Cycle counter and read snapshot
    // ------------------------------------------------------------------
    logic [7:0] ctr_byte;

`ifdef MEM_IO_CYCLE_COUNTER_EN
    logic [31:0] cnt_q, cnt_d;
    logic [31:0] snap_q, snap_d;

    // Free-running counter; a read of 0x30004 captures it for coherent bytes
    always_comb begin
        cnt_d  = cnt_q + 32'd1;
        snap_d = snap_q;
        if (rd_en && is_io_ctl) begin
            snap_d = cnt_q;
        end
    end

    // Counter and snapshot registers
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q  <= '0;
            snap_q <= '0;
        end else begin
            cnt_q  <= cnt_d;
            snap_q <= snap_d;
        end
    end

    // Byte 0 comes from the live counter (it is the value being snapshotted)
    always_comb begin
        ctr_byte = 8'h00;
        case (in_cpu_addr[1:0])
            2'd0:    ctr_byte = cnt_q[7:0];
            2'd1:    ctr_byte = snap_q[15:8];
            2'd2:    ctr_byte = snap_q[23:16];
            default: ctr_byte = snap_q[31:24];
        endcase
    end
`else
    assign ctr_byte = 8'h00;
`endif

    // ------------------------------------------------------------------
    // Read data path
    // ------------------------------------------------------------------
    logic [7:0] io_rdata;
    logic       sel_ram_q, sel_ram_d;
    logic [7:0] io_rd_q, io_rd_d;

    // I/O read mux; unmapped offsets read as zero
    always_comb begin
        io_rdata = 8'h00;
        if (is_io_data) begin
            io_rdata = in_rx_valid ? in_rx_data : 8'h00;
        end else if (is_io_ctr) begin
            io_rdata = ctr_byte;
        end
    end

    // Output source select and I/O byte hold their value across writes
    always_comb begin
        sel_ram_d = sel_ram_q;
        io_rd_d   = io_rd_q;
        if (rd_en) begin
            sel_ram_d = !is_io;
            io_rd_d   = io_rdata;
        end
    end

    // Output registers; reset selects the zeroed I/O byte
    always_ff @(posedge clk) begin
        if (rst) begin
            sel_ram_q <= 1'b0;
            io_rd_q   <= 8'h00;
        end else begin
            sel_ram_q <= sel_ram_d;
            io_rd_q   <= io_rd_d;
        end
    end

    assign out_cpu_data = sel_ram_q ? ram_rd_q : io_rd_q;
    assign out_rx_pop   = !rst && rd_en && is_io_data && in_rx_valid;

    // ------------------------------------------------------------------
    // TX FIFO, stop flag, overflow flag
    // ------------------------------------------------------------------
    logic [7:0]    fifo_mem [0:TX_DEPTH-1];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          near_full_q, near_full_d;
    logic          overflow_q, overflow_d;
    logic          stop_q, stop_d;
    logic          push_req;
    logic [7:0]    push_data;
    logic          pop;
    logic          push_acc;

    // 0x30004 writes always enqueue a zero marker; 0x30000 skips zero bytes
    assign push_req  = wr_en && ((is_io_data && (in_cpu_data != 8'h00)) || is_io_ctl);
    assign push_data = is_io_ctl ? 8'h00 : in_cpu_data;
    assign pop       = (count_q != '0) && in_tx_ready;
    assign push_acc  = push_req && ((count_q != FULL_CNT) || pop);

    // FIFO bookkeeping and sticky flags
    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        overflow_d  = overflow_q;
        stop_d      = stop_q;
        if (push_acc) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        if (push_acc && !pop) begin
            count_d = count_q + CW'(1);
        end else if (!push_acc && pop) begin
            count_d = count_q - CW'(1);
        end
        if (push_req && !push_acc) begin
            overflow_d = 1'b1;
        end
        if (wr_en && is_io_ctl) begin
            stop_d = 1'b1;
        end
        near_full_d = (count_d >= NEAR_FULL_CNT);
    end

    // FIFO storage write
    always_ff @(posedge clk) begin
        if (!rst && push_acc) begin
            fifo_mem[wr_ptr_q] <= push_data;
        end
    end

    // FIFO pointers, count and flags; reset flushes the queue
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            near_full_q <= 1'b0;
            overflow_q  <= 1'b0;
            stop_q      <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            near_full_q <= near_full_d;
            overflow_q  <= overflow_d;
            stop_q      <= stop_d;
        end
    end

    assign out_tx_data        = fifo_mem[rd_ptr_q];
    assign out_tx_valid       = (count_q != '0);
    assign out_io_buffer_full = near_full_q;
    assign out_tx_overflow    = overflow_q;
    assign out_program_stop   = stop_q;

endmodule

// File: tb/tb_mem_io_responder.sv
// Directed testbench for mem_io_responder. Counter expectations follow
// MEM_IO_CYCLE_COUNTER_EN (zero when the macro is not defined).
module tb_mem_io_responder;

    localparam logic [31:0] IDLE_ADDR = 32'h0001_0000;
    localparam logic [31:0] IO_DATA   = 32'h0003_0000;
    localparam logic [31:0] IO_CTL    = 32'h0003_0004;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] addr;
    logic        wr;
    logic [7:0]  wdata;
    logic [7:0]  cpu_data;
    logic        buf_full;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_pop;
    logic        prog_stop;
    logic        tx_ovf;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    mem_io_responder dut (
        .clk                (clk),
        .rst                (rst),
        .in_cpu_addr        (addr),
        .in_cpu_wr          (wr),
        .in_cpu_data        (wdata),
        .out_cpu_data       (cpu_data),
        .out_io_buffer_full (buf_full),
        .out_tx_data        (tx_data),
        .out_tx_valid       (tx_valid),
        .in_tx_ready        (tx_ready),
        .in_rx_data         (rx_data),
        .in_rx_valid        (rx_valid),
        .out_rx_pop         (rx_pop),
        .out_program_stop   (prog_stop),
        .out_tx_overflow    (tx_ovf)
    );

    // Advance one clock; outputs are sampled 1 time unit after the edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        addr = IDLE_ADDR;
        wr   = 1'b0;
    endtask

    // One bus write cycle followed by return to idle
    task automatic bus_write(input logic [31:0] a, input logic [7:0] d);
        addr  = a;
        wr    = 1'b1;
        wdata = d;
        tick();
        $display("wr  addr=%h data=%h", a, d);
        idle();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle();
        tick();
        tick();
        n_checks++; if (cpu_data !== 8'h00) begin n_fail++; $display("FAIL reset_cpu_data: got %h want 00", cpu_data); end
        n_checks++; if (buf_full !== 1'b0) begin n_fail++; $display("FAIL reset_buf_full: got %b want 0", buf_full); end
        n_checks++; if (tx_valid !== 1'b0) begin n_fail++; $display("FAIL reset_tx_valid: got %b want 0", tx_valid); end
        n_checks++; if (rx_pop !== 1'b0) begin n_fail++; $display("FAIL reset_rx_pop: got %b want 0", rx_pop); end
        n_checks++; if (prog_stop !== 1'b0) begin n_fail++; $display("FAIL reset_stop: got %b want 0", prog_stop); end
        n_checks++; if (tx_ovf !== 1'b0) begin n_fail++; $display("FAIL reset_overflow: got %b want 0", tx_ovf); end
        rst = 1'b0;
    endtask

    task automatic test_ram();
        bus_write(32'h0000_0123, 8'hA5);
        tick();
        addr = 32'h0000_0123; wr = 1'b0;
        tick();
        $display("rd  addr=%h data=%h", addr, cpu_data);
        n_checks++; if (cpu_data !== 8'hA5) begin n_fail++; $display("FAIL ram_read: got %h want a5", cpu_data); end
        // Read-after-write at the top RAM byte, no gap cycle
        addr = 32'h0001_FFFF; wr = 1'b1; wdata = 8'h3C;
        tick();
        wr = 1'b0;
        tick();
        $display("rd  addr=%h data=%h", addr, cpu_data);
        n_checks++; if (cpu_data !== 8'h3C) begin n_fail++; $display("FAIL ram_raw: got %h want 3c", cpu_data); end
        // Held across a write cycle
        addr = 32'h0000_0200; wr = 1'b1; wdata = 8'h99;
        tick();
        n_checks++; if (cpu_data !== 8'h3C) begin n_fail++; $display("FAIL ram_hold: got %h want 3c", cpu_data); end
        // addr[17:16]=10 is RAM, aliasing to 0x00123
        addr = 32'h0002_0123; wr = 1'b0;
        tick();
        $display("rd  addr=%h data=%h", addr, cpu_data);
        n_checks++; if (cpu_data !== 8'hA5) begin n_fail++; $display("FAIL ram_alias: got %h want a5", cpu_data); end
        // Unmapped I/O: write ignored, read returns zero
        bus_write(32'h0003_0008, 8'h5A);
        n_checks++; if (tx_valid !== 1'b0) begin n_fail++; $display("FAIL unmapped_wr: got tx_valid=%b want 0", tx_valid); end
        addr = 32'h0003_0008; wr = 1'b0;
        tick();
        $display("rd  addr=%h data=%h", addr, cpu_data);
        n_checks++; if (cpu_data !== 8'h00) begin n_fail++; $display("FAIL unmapped_rd: got %h want 00", cpu_data); end
        idle();
    endtask

    task automatic test_tx();
        tx_ready = 1'b0;
        bus_write(IO_DATA, 8'h41);
        bus_write(IO_DATA, 8'h00);
        bus_write(IO_DATA, 8'h42);
        n_checks++; if (tx_valid !== 1'b1) begin n_fail++; $display("FAIL tx_valid_after_push: got %b want 1", tx_valid); end
        n_checks++; if (tx_data !== 8'h41) begin n_fail++; $display("FAIL tx_head: got %h want 41", tx_data); end
        tx_ready = 1'b1;
        tick();
        n_checks++; if (tx_data !== 8'h42) begin n_fail++; $display("FAIL tx_second: got %h want 42", tx_data); end
        n_checks++; if (tx_valid !== 1'b1) begin n_fail++; $display("FAIL tx_valid_second: got %b want 1", tx_valid); end
        tick();
        n_checks++; if (tx_valid !== 1'b0) begin n_fail++; $display("FAIL tx_drained: got %b want 0", tx_valid); end
        tx_ready = 1'b0;
    endtask

    task automatic test_full_overflow();
        int   n;
        logic [7:0] last;
        tx_ready = 1'b0;
        for (int i = 0; i < 13; i++) bus_write(IO_DATA, 8'h55);
        n_checks++; if (buf_full !== 1'b0) begin n_fail++; $display("FAIL full_at_13: got %b want 0", buf_full); end
        bus_write(IO_DATA, 8'h55);
        n_checks++; if (buf_full !== 1'b1) begin n_fail++; $display("FAIL full_at_14: got %b want 1", buf_full); end
        bus_write(IO_DATA, 8'h55);
        bus_write(IO_DATA, 8'h55);
        n_checks++; if (tx_ovf !== 1'b0) begin n_fail++; $display("FAIL ovf_at_16: got %b want 0", tx_ovf); end
        // Push and pop together at full
        tx_ready = 1'b1;
        bus_write(IO_DATA, 8'h66);
        tx_ready = 1'b0;
        n_checks++; if (tx_ovf !== 1'b0) begin n_fail++; $display("FAIL ovf_push_pop: got %b want 0", tx_ovf); end
        n_checks++; if (buf_full !== 1'b1) begin n_fail++; $display("FAIL full_push_pop: got %b want 1", buf_full); end
        // 17th byte dropped
        bus_write(IO_DATA, 8'h77);
        n_checks++; if (tx_ovf !== 1'b1) begin n_fail++; $display("FAIL ovf_drop: got %b want 1", tx_ovf); end
        // Drain and count entries
        n = 0;
        last = 8'h00;
        tx_ready = 1'b1;
        for (int i = 0; i < 24; i++) begin
            if (tx_valid !== 1'b1) break;
            n++;
            last = tx_data;
            tick();
        end
        tx_ready = 1'b0;
        $display("drain count=%0d last=%h", n, last);
        n_checks++; if (n != 16) begin n_fail++; $display("FAIL drain_count: got %0d want 16", n); end
        n_checks++; if (last !== 8'h66) begin n_fail++; $display("FAIL drain_last: got %h want 66", last); end
        n_checks++; if (buf_full !== 1'b0) begin n_fail++; $display("FAIL full_after_drain: got %b want 0", buf_full); end
    endtask

    task automatic test_rx();
        rx_valid = 1'b1; rx_data = 8'h37;
        tick();
        n_checks++; if (rx_pop !== 1'b0) begin n_fail++; $display("FAIL rx_pop_idle: got %b want 0", rx_pop); end
        addr = IO_DATA; wr = 1'b0;
        #1;
        n_checks++; if (rx_pop !== 1'b1) begin n_fail++; $display("FAIL rx_pop: got %b want 1", rx_pop); end
        tick();
        idle();
        #1;
        $display("rd  addr=%h data=%h", IO_DATA, cpu_data);
        n_checks++; if (cpu_data !== 8'h37) begin n_fail++; $display("FAIL rx_data: got %h want 37", cpu_data); end
        n_checks++; if (rx_pop !== 1'b0) begin n_fail++; $display("FAIL rx_pop_end: got %b want 0", rx_pop); end
        rx_valid = 1'b0;
        addr = IO_DATA; wr = 1'b0;
        #1;
        n_checks++; if (rx_pop !== 1'b0) begin n_fail++; $display("FAIL rx_pop_novalid: got %b want 0", rx_pop); end
        tick();
        $display("rd  addr=%h data=%h", IO_DATA, cpu_data);
        n_checks++; if (cpu_data !== 8'h00) begin n_fail++; $display("FAIL rx_novalid_data: got %h want 00", cpu_data); end
        idle();
    endtask

    task automatic test_stop_reset();
        tx_ready = 1'b0;
        bus_write(IO_CTL, 8'hAB);
        n_checks++; if (prog_stop !== 1'b1) begin n_fail++; $display("FAIL stop_set: got %b want 1", prog_stop); end
        n_checks++; if (tx_valid !== 1'b1) begin n_fail++; $display("FAIL stop_push_valid: got %b want 1", tx_valid); end
        n_checks++; if (tx_data !== 8'h00) begin n_fail++; $display("FAIL stop_push_data: got %h want 00", tx_data); end
        // Still served after stop
        addr = 32'h0000_0123; wr = 1'b0;
        tick();
        n_checks++; if (cpu_data !== 8'hA5) begin n_fail++; $display("FAIL read_after_stop: got %h want a5", cpu_data); end
        n_checks++; if (tx_ovf !== 1'b1) begin n_fail++; $display("FAIL ovf_sticky: got %b want 1", tx_ovf); end
        // One-cycle reset with an in-flight RAM write that must be dropped
        rst = 1'b1;
        addr = 32'h0000_0123; wr = 1'b1; wdata = 8'h11;
        tick();
        rst = 1'b0;
        idle();
        $display("reset pulse");
        n_checks++; if (cpu_data !== 8'h00) begin n_fail++; $display("FAIL rst_cpu_data: got %h want 00", cpu_data); end
        n_checks++; if (prog_stop !== 1'b0) begin n_fail++; $display("FAIL rst_stop: got %b want 0", prog_stop); end
        n_checks++; if (tx_ovf !== 1'b0) begin n_fail++; $display("FAIL rst_overflow: got %b want 0", tx_ovf); end
        n_checks++; if (tx_valid !== 1'b0) begin n_fail++; $display("FAIL rst_flush: got %b want 0", tx_valid); end
        n_checks++; if (buf_full !== 1'b0) begin n_fail++; $display("FAIL rst_full: got %b want 0", buf_full); end
        addr = 32'h0000_0123; wr = 1'b0;
        tick();
        n_checks++; if (cpu_data !== 8'hA5) begin n_fail++; $display("FAIL ram_kept: got %h want a5", cpu_data); end
        idle();
    endtask

    task automatic test_counter();
        logic [31:0] exp_a;
        logic [31:0] exp_b;
`ifdef MEM_IO_CYCLE_COUNTER_EN
        exp_a = 32'd1000;
        exp_b = 32'd1305;
`else
        exp_a = 32'd0;
        exp_b = 32'd0;
`endif
        rst = 1'b1;
        idle();
        tick();
        rst = 1'b0;
        repeat (1000) tick();
        // Four consecutive reads; snapshot taken at the 0x30004 read
        for (int b = 0; b < 4; b++) begin
            addr = IO_CTL + 32'(b); wr = 1'b0;
            tick();
            $display("rd  addr=%h data=%h", addr, cpu_data);
            n_checks++;
            if (cpu_data !== exp_a[8*b +: 8]) begin
                n_fail++;
                $display("FAIL ctr_byte%0d: got %h want %h", b, cpu_data, exp_a[8*b +: 8]);
            end
        end
        idle();
        repeat (300) tick();
        // Without a new 0x30004 read, byte 1 still comes from the old snapshot
        addr = IO_CTL + 32'd1; wr = 1'b0;
        tick();
        n_checks++; if (cpu_data !== exp_a[15:8]) begin n_fail++; $display("FAIL ctr_snap_stable: got %h want %h", cpu_data, exp_a[15:8]); end
        addr = IO_CTL;
        tick();
        n_checks++; if (cpu_data !== exp_b[7:0]) begin n_fail++; $display("FAIL ctr_reload_b0: got %h want %h", cpu_data, exp_b[7:0]); end
        addr = IO_CTL + 32'd1;
        tick();
        n_checks++; if (cpu_data !== exp_b[15:8]) begin n_fail++; $display("FAIL ctr_reload_b1: got %h want %h", cpu_data, exp_b[15:8]); end
        idle();
    endtask

    initial begin
        rst      = 1'b1;
        addr     = IDLE_ADDR;
        wr       = 1'b0;
        wdata    = 8'h00;
        tx_ready = 1'b0;
        rx_data  = 8'h00;
        rx_valid = 1'b0;
        test_reset();
        test_ram();
        test_tx();
        test_full_overflow();
        test_rx();
        test_stop_reset();
        test_counter();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
